// File: rtl/pmp_seq_checker.sv
// Sequential PMP lookup: walks entries lowest-index first, one per cycle, driving
// an external per-entry matcher and returning a fault/no-fault response.
module pmp_seq_checker #(
  parameter int N_ENTRIES = 16,
  parameter int IDX_W     = $clog2(N_ENTRIES)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [31:0]             req_addr,
  input  logic [1:0]              req_size,
  input  logic [1:0]              req_type,
  input  logic                    req_priv_m,
  input  logic [8*N_ENTRIES-1:0]  pmpcfg_flat,
  input  logic [32*N_ENTRIES-1:0] pmpaddr_flat,
  output logic                    busy,
  output logic [31:0]             chk_addr,
  output logic [31:0]             chk_addr_n,
  output logic [31:0]             chk_addr_n_1,
  output logic [1:0]              chk_size,
  output logic [1:0]              chk_a,
  input  logic                    chk_match,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_fault,
  output logic                    rsp_matched,
  output logic [IDX_W-1:0]        rsp_entry
);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    RESP
  } state_e;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ENTRIES - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      addr_q, addr_d;
  logic [1:0]       size_q, size_d;
  logic [1:0]       type_q, type_d;
  logic             priv_q, priv_d;
  logic             fault_q, fault_d;
  logic             matched_q, matched_d;
  logic [IDX_W-1:0] entry_q, entry_d;

  logic [7:0]       cfg   [N_ENTRIES];
  logic [31:0]      paddr [N_ENTRIES];
  logic [7:0]       cur_cfg;
  logic [31:0]      cur_paddr;
  logic [31:0]      prev_paddr;
  logic [IDX_W-1:0] idx_prev;
  logic             unused_cfg_bits;

  for (genvar g = 0; g < N_ENTRIES; g++) begin : g_unpack
    assign cfg[g]   = pmpcfg_flat[8*g +: 8];
    assign paddr[g] = pmpaddr_flat[32*g +: 32];
  end

  assign idx_prev        = idx_q - IDX_W'(1);
  assign cur_cfg         = cfg[idx_q];
  assign cur_paddr       = paddr[idx_q];
  assign prev_paddr      = (idx_q == '0) ? '0 : paddr[idx_prev];
  assign unused_cfg_bits = ^cur_cfg[6:5];

  // Reserved type always faults; M-mode bypasses unlocked entries.
  function automatic logic calc_fault(input logic [1:0] t, input logic pm,
                                      input logic [7:0] c);
    logic perm;
    case (t)
      2'b00:   perm = c[0];
      2'b01:   perm = c[1];
      2'b10:   perm = c[2];
      default: perm = 1'b0;
    endcase
    if (t == 2'b11)       return 1'b1;
    else if (pm && !c[7]) return 1'b0;
    else                  return !perm;
  endfunction

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    addr_d       = addr_q;
    size_d       = size_q;
    type_d       = type_q;
    priv_d       = priv_q;
    fault_d      = fault_q;
    matched_d    = matched_q;
    entry_d      = entry_q;
    req_ready    = 1'b0;
    chk_addr     = '0;
    chk_addr_n   = '0;
    chk_addr_n_1 = '0;
    chk_size     = '0;
    chk_a        = '0;

    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          addr_d  = req_addr;
          size_d  = req_size;
          type_d  = req_type;
          priv_d  = req_priv_m;
          idx_d   = '0;
          state_d = SCAN;
        end
      end

      SCAN: begin
        chk_addr     = addr_q;
        chk_addr_n   = cur_paddr;
        chk_addr_n_1 = prev_paddr;
        chk_size     = size_q;
        chk_a        = cur_cfg[4:3];
        if (chk_match) begin
          entry_d   = idx_q;
          matched_d = 1'b1;
          fault_d   = calc_fault(type_q, priv_q, cur_cfg);
          state_d   = RESP;
        end else if (idx_q == LAST_IDX) begin
          entry_d   = '0;
          matched_d = 1'b0;
          fault_d   = !priv_q;
          state_d   = RESP;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end

      RESP: begin
        if (rsp_ready) begin
          idx_d   = '0;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      addr_q    <= '0;
      size_q    <= '0;
      type_q    <= '0;
      priv_q    <= 1'b0;
      fault_q   <= 1'b0;
      matched_q <= 1'b0;
      entry_q   <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      type_q    <= type_d;
      priv_q    <= priv_d;
      fault_q   <= fault_d;
      matched_q <= matched_d;
      entry_q   <= entry_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign rsp_valid   = (state_q == RESP);
  assign rsp_fault   = fault_q;
  assign rsp_matched = matched_q;
  assign rsp_entry   = entry_q;

endmodule
